binary_calc_top: RTL and testbench
==================================

BINARY_CALC_TOP -- requirements
Module: binary_calc_top

Interface
REQ-001 Parameter KEY, default 4'b1010: activation key, checked MSB first on INPUT_KEY.
REQ-002 Parameter MEM_DEPTH, default 256: result-memory words (32 bits each), addressed by ADDR.
REQ-003 CLK  in  1  single system clock; all logic on rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 INPUT_KEY  in  1  serial key/mode bit, sampled once per clock while inactive and VALID_CMD=1.
REQ-006 VALID_CMD  in  1  command qualifier (key entry when inactive; command strobe when active).
REQ-007 RW_MEM  in  1  mode-1 command type: 1=write ALU packet to memory, 0=read memory and transmit.
REQ-008 ADDR  in  8  memory address.
REQ-009 IN_A, IN_B  in  8 each  ALU operands, unsigned.
REQ-010 SEL  in  4  ALU operation select.
REQ-011 CONFIG_DIV  in  1  load DIN into divider register.
REQ-012 DIN  in  32  bit-period divisor, in CLK cycles.
REQ-013 CALC_ACTIVE  out  1  key accepted; CALC_MODE  out  1  latched mode bit.
REQ-014 BUSY  out  1  serial transfer in progress; D_OUT_VALID  out  1  D_OUT carries a packet bit.
REQ-015 D_OUT  out  1  serial data, MSB first; CLK_Tx  out  1  serial bit clock.

Function
REQ-016 Key FSM states IDLE,K1,K2,K3,K4; while inactive, each VALID_CMD=1 cycle advances on a matching KEY bit; mismatch goes to K1 if bit=1, else IDLE; VALID_CMD=0 holds state.
REQ-017 In K4 the next sampled bit is latched into CALC_MODE and CALC_ACTIVE is set the following cycle; both hold until RESET.
REQ-018 ALU (combinational): SEL 0 A+B, 1 A-B, 2 A*B low 8, 3 A/B, 4 A%B, 5 A<<1, 6 A>>1, 7 AND, 8 OR, 9 XOR, 10 ~A, 11 NAND, 12 NOR, 13 XNOR, 14 A<B?1:0, 15 A==B?1:0.
REQ-019 FLAGS[3:0] = {Z result==0, C add carry / sub borrow / mul high byte nonzero, N result[7], E divide-or-mod by zero}; B=0 on SEL 3/4 gives result 0, E=1.
REQ-020 Packet[31:0] = {IN_A, IN_B, SEL, RESULT[7:0], FLAGS}.
REQ-021 Command accepted on a cycle with CALC_ACTIVE=1, VALID_CMD=1, BUSY=0, DIV!=0 and command armed; acceptance disarms; VALID_CMD=0 re-arms; arming also set on activation.
REQ-022 Mode 0 accepted command: transmit current packet.
REQ-023 Mode 1, RW_MEM=1: store packet at ADDR at acceptance edge; no transfer, BUSY stays 0.
REQ-024 Mode 1, RW_MEM=0: transmit word at ADDR, read at acceptance edge.
REQ-025 Transfer accepted at edge T: BUSY=1 and D_OUT_VALID=1 from T+1 through T+32*DIV; bit 31 first, each bit held DIV cycles; BUSY, D_OUT_VALID, D_OUT return 0 at T+32*DIV+1.
REQ-026 CLK_Tx high for first ceil(DIV/2) cycles of each bit period, low otherwise and when idle; receiver samples D_OUT on CLK_Tx falling edge (DIV=1: CLK_Tx constant high during transfer).
REQ-027 CONFIG_DIV=1 with BUSY=0 loads DIV<=DIN next edge; ignored while BUSY; same-cycle CONFIG_DIV and command: DIV loads, command waits one cycle.
REQ-028 ADDR >= MEM_DEPTH: write ignored, read transmits 32'h0.

Reset
REQ-029 RESET=1 at an edge: CALC_ACTIVE, CALC_MODE, BUSY, D_OUT_VALID, D_OUT, CLK_Tx = 0, key FSM IDLE, DIV = 0, armed = 0; memory not cleared.
REQ-030 RESET during a transfer aborts it; no further bits emitted.

Configuration
REQ-031 Macro BINARY_CALC_MEM_EN defined: memory and mode-1 read/write present; undefined: no memory, mode-1 writes ignored, mode-1 reads transmit 32'h0.

Structure
REQ-032 Shared package: SEL opcode constants, FLAGS bit indices, key-FSM state enum, packet field widths.
REQ-033 One sub-module calc_alu (IN_A, IN_B, SEL -> RESULT, FLAGS); key FSM, memory, serializer inline.
REQ-034 Bench clock generator Clock (10 ns period) is simulation-only, not part of RTL.

Verification
REQ-035 Reset, VALID_CMD=1, INPUT_KEY 1,0,1,0,0 -> CALC_ACTIVE=1, CALC_MODE=0; key 1,1,0,1,0,1,0 -> activation after mismatch recovery.
REQ-036 Mode 0, A=10, B=7, SEL=0, DIN=1 via CONFIG_DIV -> 32 bits 0x0A070110 on D_OUT, BUSY 32 cycles.
REQ-037 Mode 1, DIN=2: write A=10,B=7,SEL=0 to ADDR 0, A=28,B=4,SEL=3 to ADDR 5; read 0 -> 0x0A070110, read 5 -> 0x1C043070, each bit 2 cycles.
REQ-038 A=5, B=0, SEL=3 mode 0 -> packet 0x05003009 (result 0, Z=1, E=1).
REQ-039 RESET mid-transfer -> all outputs 0 next cycle; CONFIG_DIV during BUSY -> DIV unchanged.

Source files
------------

// File: rtl/binary_calc_pkg.sv
// Shared definitions for the binary calculator: ALU opcodes, flag positions,
// key-FSM states and result-packet layout.
package binary_calc_pkg;

    localparam int OPND_W = 8;
    localparam int SEL_W  = 4;
    localparam int RES_W  = 8;
    localparam int FLAG_W = 4;
    localparam int PKT_W  = 2 * OPND_W + SEL_W + RES_W + FLAG_W;

    localparam logic [SEL_W-1:0] SEL_ADD  = 4'd0;
    localparam logic [SEL_W-1:0] SEL_SUB  = 4'd1;
    localparam logic [SEL_W-1:0] SEL_MUL  = 4'd2;
    localparam logic [SEL_W-1:0] SEL_DIV  = 4'd3;
    localparam logic [SEL_W-1:0] SEL_MOD  = 4'd4;
    localparam logic [SEL_W-1:0] SEL_SHL  = 4'd5;
    localparam logic [SEL_W-1:0] SEL_SHR  = 4'd6;
    localparam logic [SEL_W-1:0] SEL_AND  = 4'd7;
    localparam logic [SEL_W-1:0] SEL_OR   = 4'd8;
    localparam logic [SEL_W-1:0] SEL_XOR  = 4'd9;
    localparam logic [SEL_W-1:0] SEL_NOT  = 4'd10;
    localparam logic [SEL_W-1:0] SEL_NAND = 4'd11;
    localparam logic [SEL_W-1:0] SEL_NOR  = 4'd12;
    localparam logic [SEL_W-1:0] SEL_XNOR = 4'd13;
    localparam logic [SEL_W-1:0] SEL_LT   = 4'd14;
    localparam logic [SEL_W-1:0] SEL_EQ   = 4'd15;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_E = 0;

    typedef enum logic [2:0] {
        KEY_IDLE,
        KEY_K1,
        KEY_K2,
        KEY_K3,
        KEY_K4
    } key_state_t;

    function automatic logic [PKT_W-1:0] make_packet(
        input logic [OPND_W-1:0] a,
        input logic [OPND_W-1:0] b,
        input logic [SEL_W-1:0]  sel,
        input logic [RES_W-1:0]  res,
        input logic [FLAG_W-1:0] flags
    );
        return {a, b, sel, res, flags};
    endfunction

endpackage

// File: rtl/binary_calc_alu.sv
// Combinational 8-bit ALU producing a result byte and Z/C/N/E flags.
module calc_alu
    import binary_calc_pkg::*;
(
    input  logic [OPND_W-1:0] in_a,
    input  logic [OPND_W-1:0] in_b,
    input  logic [SEL_W-1:0]  sel,
    output logic [RES_W-1:0]  result,
    output logic [FLAG_W-1:0] flags
);

    logic [OPND_W:0]     sum;
    logic [2*OPND_W-1:0] prod;
    logic                carry;
    logic                div_zero;

    assign sum  = {1'b0, in_a} + {1'b0, in_b};
    assign prod = {8'b0, in_a} * {8'b0, in_b};

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        div_zero = 1'b0;
        case (sel)
            SEL_ADD: begin
                result = sum[RES_W-1:0];
                carry  = sum[OPND_W];
            end
            SEL_SUB: begin
                result = in_a - in_b;
                carry  = (in_a < in_b);
            end
            SEL_MUL: begin
                result = prod[RES_W-1:0];
                carry  = |prod[2*OPND_W-1:OPND_W];
            end
            SEL_DIV: begin
                if (in_b == '0) div_zero = 1'b1;
                else            result   = in_a / in_b;
            end
            SEL_MOD: begin
                if (in_b == '0) div_zero = 1'b1;
                else            result   = in_a % in_b;
            end
            SEL_SHL:  result = {in_a[OPND_W-2:0], 1'b0};
            SEL_SHR:  result = {1'b0, in_a[OPND_W-1:1]};
            SEL_AND:  result = in_a & in_b;
            SEL_OR:   result = in_a | in_b;
            SEL_XOR:  result = in_a ^ in_b;
            SEL_NOT:  result = ~in_a;
            SEL_NAND: result = ~(in_a & in_b);
            SEL_NOR:  result = ~(in_a | in_b);
            SEL_XNOR: result = ~(in_a ^ in_b);
            SEL_LT:   result = {7'b0, (in_a < in_b)};
            SEL_EQ:   result = {7'b0, (in_a == in_b)};
            default:  result = '0;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = carry;
        flags[FLAG_N] = result[RES_W-1];
        flags[FLAG_E] = div_zero;
    end

endmodule

// File: rtl/binary_calc_top.sv
// Key-activated calculator: serial key unlock, ALU packet build, optional
// result memory (BINARY_CALC_MEM_EN) and a divided-clock serial transmitter.
//
// state    | meaning
// KEY_IDLE | nothing matched yet, expecting KEY[3]
// KEY_K1   | KEY[3] matched, expecting KEY[2]
// KEY_K2   | KEY[3:2] matched, expecting KEY[1]
// KEY_K3   | KEY[3:1] matched, expecting KEY[0]
// KEY_K4   | full key matched, next sampled bit becomes the mode
module binary_calc_top
    import binary_calc_pkg::*;
#(
    parameter logic [3:0] KEY       = 4'b1010,
    parameter int         MEM_DEPTH = 256
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              INPUT_KEY,
    input  logic              VALID_CMD,
    input  logic              RW_MEM,
    input  logic [7:0]        ADDR,
    input  logic [OPND_W-1:0] IN_A,
    input  logic [OPND_W-1:0] IN_B,
    input  logic [SEL_W-1:0]  SEL,
    input  logic              CONFIG_DIV,
    input  logic [31:0]       DIN,
    output logic              CALC_ACTIVE,
    output logic              CALC_MODE,
    output logic              BUSY,
    output logic              D_OUT_VALID,
    output logic              D_OUT,
    output logic              CLK_Tx
);

    key_state_t state, state_next;
    logic       exp_bit;
    logic       activate;
    logic       calc_active, calc_mode;

    logic [31:0]       div;
    logic              armed;
    logic              busy;
    logic [PKT_W-1:0]  shreg;
    logic [4:0]        bit_cnt;
    logic [31:0]       per_cnt;

    logic [RES_W-1:0]  alu_result;
    logic [FLAG_W-1:0] alu_flags;
    logic [PKT_W-1:0]  packet;
    logic [PKT_W-1:0]  mem_word;
    logic [PKT_W-1:0]  tx_word;
    logic              cfg_load, accept, start_tx;

    calc_alu u_alu (
        .in_a   (IN_A),
        .in_b   (IN_B),
        .sel    (SEL),
        .result (alu_result),
        .flags  (alu_flags)
    );

    assign packet = make_packet(IN_A, IN_B, SEL, alu_result, alu_flags);

    always_comb begin
        state_next = state;
        activate   = 1'b0;
        case (state)
            KEY_IDLE: exp_bit = KEY[3];
            KEY_K1:   exp_bit = KEY[2];
            KEY_K2:   exp_bit = KEY[1];
            KEY_K3:   exp_bit = KEY[0];
            default:  exp_bit = 1'b0;
        endcase
        if (!calc_active && VALID_CMD) begin
            if (state == KEY_K4) begin
                activate   = 1'b1;
                state_next = KEY_IDLE;
            end else if (INPUT_KEY == exp_bit) begin
                case (state)
                    KEY_IDLE: state_next = KEY_K1;
                    KEY_K1:   state_next = KEY_K2;
                    KEY_K2:   state_next = KEY_K3;
                    default:  state_next = KEY_K4;
                endcase
            end else begin
                // A stray 1 may itself be the start of a fresh key.
                state_next = INPUT_KEY ? KEY_K1 : KEY_IDLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= KEY_IDLE;
            calc_active <= 1'b0;
            calc_mode   <= 1'b0;
        end else begin
            state <= state_next;
            if (activate) begin
                calc_active <= 1'b1;
                calc_mode   <= INPUT_KEY;
            end
        end
    end

    // A divisor load takes priority; a coincident command retries next cycle.
    assign cfg_load = CONFIG_DIV && !busy;
    assign accept   = calc_active && VALID_CMD && !busy && (div != '0)
                      && armed && !CONFIG_DIV;
    assign start_tx = accept && (!calc_mode || !RW_MEM);
    assign tx_word  = calc_mode ? mem_word : packet;

`ifdef BINARY_CALC_MEM_EN
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [PKT_W-1:0] mem [MEM_DEPTH];
    logic [AW-1:0]    mem_idx;
    logic             addr_ok;

    assign addr_ok  = ({24'b0, ADDR} < 32'(MEM_DEPTH));
    assign mem_idx  = AW'(ADDR);
    assign mem_word = addr_ok ? mem[mem_idx] : '0;

    always_ff @(posedge CLK) begin
        if (accept && calc_mode && RW_MEM && addr_ok)
            mem[mem_idx] <= packet;
    end
`else
    logic unused_mem_inputs;

    assign unused_mem_inputs = ^{ADDR, 32'(MEM_DEPTH)};
    assign mem_word          = '0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            div     <= '0;
            armed   <= 1'b0;
            busy    <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            per_cnt <= '0;
        end else begin
            if (cfg_load)
                div <= DIN;

            if (accept)
                armed <= 1'b0;
            else if (activate || !VALID_CMD)
                armed <= 1'b1;

            if (busy) begin
                if (per_cnt == '0) begin
                    if (bit_cnt == '0) begin
                        busy <= 1'b0;
                    end else begin
                        shreg   <= {shreg[PKT_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt - 5'd1;
                        per_cnt <= div - 32'd1;
                    end
                end else begin
                    per_cnt <= per_cnt - 32'd1;
                end
            end else if (start_tx) begin
                busy    <= 1'b1;
                shreg   <= tx_word;
                bit_cnt <= 5'd31;
                per_cnt <= div - 32'd1;
            end
        end
    end

    // per_cnt counts down through the bit, so the high phase is its upper part.
    assign CLK_Tx      = busy && (per_cnt >= (div >> 1));
    assign D_OUT       = busy && shreg[PKT_W-1];
    assign D_OUT_VALID = busy;
    assign BUSY        = busy;
    assign CALC_ACTIVE = calc_active;
    assign CALC_MODE   = calc_mode;

endmodule

// File: tb/tb_binary_calc_top.sv
// Scoreboard bench for binary_calc_top: stimulus pushes expected serial words,
// a monitor rebuilds each transfer from D_OUT and compares.
module tb_binary_calc_top;

    logic        CLK = 1'b0;
    logic        RESET, INPUT_KEY, VALID_CMD, RW_MEM, CONFIG_DIV;
    logic [7:0]  ADDR, IN_A, IN_B;
    logic [3:0]  SEL;
    logic [31:0] DIN;
    logic        CALC_ACTIVE, CALC_MODE, BUSY, D_OUT_VALID, D_OUT, CLK_Tx;

    always #5 CLK = ~CLK;

    binary_calc_top dut (
        .CLK(CLK), .RESET(RESET), .INPUT_KEY(INPUT_KEY), .VALID_CMD(VALID_CMD),
        .RW_MEM(RW_MEM), .ADDR(ADDR), .IN_A(IN_A), .IN_B(IN_B), .SEL(SEL),
        .CONFIG_DIV(CONFIG_DIV), .DIN(DIN), .CALC_ACTIVE(CALC_ACTIVE),
        .CALC_MODE(CALC_MODE), .BUSY(BUSY), .D_OUT_VALID(D_OUT_VALID),
        .D_OUT(D_OUT), .CLK_Tx(CLK_Tx)
    );

    typedef struct {
        logic [31:0] word;
        int          div;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cur_div = 0;
    logic [31:0] ref_mem [256];
    int          written[$];
`ifdef BINARY_CALC_MEM_EN
    localparam bit MEM_EN = 1'b1;
`else
    localparam bit MEM_EN = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference calculator written straight from the opcode table.
    function automatic logic [31:0] ref_packet(input int a, input int b, input int sel);
        int r;
        bit c, e, z, n;
        c = 0; e = 0; r = 0;
        case (sel)
            0:  begin r = a + b; c = (r > 255); end
            1:  begin r = a - b; c = (a < b); end
            2:  begin r = a * b; c = (r > 255); end
            3:  if (b == 0) e = 1; else r = a / b;
            4:  if (b == 0) e = 1; else r = a % b;
            5:  r = a * 2;
            6:  r = a / 2;
            7:  r = a & b;
            8:  r = a | b;
            9:  r = a ^ b;
            10: r = 255 - a;
            11: r = 255 - (a & b);
            12: r = 255 - (a | b);
            13: r = 255 - (a ^ b);
            14: r = (a < b) ? 1 : 0;
            default: r = (a == b) ? 1 : 0;
        endcase
        r = r & 255;
        z = (r == 0);
        n = (r >= 128);
        return 32'((a << 24) | (b << 16) | (sel << 12) | (r << 4)
                   | (int'(z) << 3) | (int'(c) << 2) | (int'(n) << 1) | int'(e));
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (BUSY === 1'b1 && k < 600) begin
            tick();
            k++;
        end
        if (BUSY !== 1'b0) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: BUSY=%b after %0d cycles", BUSY, k);
        end
    endtask

    task automatic send_key(input logic b);
        VALID_CMD = 1'b1;
        INPUT_KEY = b;
        tick();
    endtask

    task automatic send_keys(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send_key(bits[i]);
        VALID_CMD = 1'b0;
        INPUT_KEY = 1'b0;
        tick();
    endtask

    task automatic set_div(input int d);
        wait_idle();
        CONFIG_DIV = 1'b1;
        DIN = 32'(d);
        tick();
        CONFIG_DIV = 1'b0;
        cur_div = d;
    endtask

    task automatic issue(input int a, input int b, input int sel, input logic rw,
                         input int addr, input bit expect_tx, input logic [31:0] exp_word);
        exp_t e;
        wait_idle();
        IN_A = 8'(a); IN_B = 8'(b); SEL = 4'(sel); RW_MEM = rw; ADDR = 8'(addr);
        VALID_CMD = 1'b1;
        if (expect_tx) begin
            e.word = exp_word;
            e.div  = cur_div;
            exp_q.push_back(e);
        end
        tick();
        VALID_CMD = 1'b0;
        check("busy_after_cmd", 32'(BUSY), 32'(expect_tx));
        tick();
    endtask

    // Monitor: collect every valid bit-cycle, then score the whole transfer.
    logic samp_d[$];
    logic samp_c[$];
    bit   aborted  = 0;
    bit   busy_bad = 0;
    bit   idle_bad = 0;
    exp_t mon_e;
    logic [31:0] mon_w;
    bit   pat_ok;

    always @(negedge CLK) begin
        if (D_OUT_VALID === 1'b1) begin
            samp_d.push_back(D_OUT);
            samp_c.push_back(CLK_Tx);
            if (RESET === 1'b1) aborted = 1;
            if (BUSY !== 1'b1) busy_bad = 1;
        end else if (samp_d.size() > 0) begin
            if (aborted) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_transfer: %0d bit-cycles, none expected", samp_d.size());
            end else begin
                mon_e = exp_q.pop_front();
                check("tx_length", 32'(samp_d.size()), 32'(32 * mon_e.div));
                mon_w  = '0;
                pat_ok = 1;
                for (int j = 0; j < samp_d.size(); j++) begin
                    if ((j % mon_e.div) == 0 && (j / mon_e.div) < 32)
                        mon_w[31 - j / mon_e.div] = samp_d[j];
                    if (samp_c[j] !== ((j % mon_e.div) < (mon_e.div + 1) / 2))
                        pat_ok = 0;
                end
                check("tx_word", mon_w, mon_e.word);
                check("clk_tx_pattern", 32'(pat_ok), 32'd1);
                check("busy_tracks_valid", 32'(busy_bad), 32'd0);
            end
            samp_d.delete();
            samp_c.delete();
            aborted  = 0;
            busy_bad = 0;
        end else if (RESET === 1'b0 && (D_OUT !== 1'b0 || CLK_Tx !== 1'b0 || BUSY !== 1'b0)) begin
            idle_bad = 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, s, ad, d;
        exp_t e;
        RESET = 1'b1; INPUT_KEY = 1'b0; VALID_CMD = 1'b0; RW_MEM = 1'b0;
        CONFIG_DIV = 1'b0; ADDR = '0; IN_A = '0; IN_B = '0; SEL = '0; DIN = '0;
        tick(); tick();
        check("reset_outputs", 32'({CALC_ACTIVE, CALC_MODE, BUSY, D_OUT_VALID, D_OUT, CLK_Tx}), 32'd0);
        RESET = 1'b0;
        tick();

        // Mode-0 activation: key 1010 then mode bit 0.
        send_key(1'b1); send_key(1'b0); send_key(1'b1); send_key(1'b0);
        check("inactive_before_mode_bit", 32'(CALC_ACTIVE), 32'd0);
        send_key(1'b0);
        VALID_CMD = 1'b0;
        tick();
        check("mode0_active", 32'(CALC_ACTIVE), 32'd1);
        check("mode0_mode", 32'(CALC_MODE), 32'd0);

        // DIV still 0: command must be ignored.
        issue(10, 7, 0, 1'b0, 0, 0, '0);

        set_div(1);
        issue(10, 7, 0, 1'b0, 0, 1, 32'h0A070110);
        issue(5, 0, 3, 1'b0, 0, 1, 32'h05003009);

        // CONFIG_DIV with a command in the same cycle: divisor wins, command follows.
        wait_idle();
        IN_A = 8'd200; IN_B = 8'd100; SEL = 4'd0;
        CONFIG_DIV = 1'b1; DIN = 32'd3; VALID_CMD = 1'b1;
        cur_div = 3;
        e.word = ref_packet(200, 100, 0);
        e.div  = 3;
        exp_q.push_back(e);
        tick();
        CONFIG_DIV = 1'b0;
        check("cfg_defers_cmd", 32'(BUSY), 32'd0);
        tick();
        VALID_CMD = 1'b0;
        check("deferred_cmd_starts", 32'(BUSY), 32'd1);
        // Divisor write while busy must not take effect.
        CONFIG_DIV = 1'b1; DIN = 32'd7;
        tick();
        CONFIG_DIV = 1'b0;
        issue(3, 9, 1, 1'b0, 0, 1, ref_packet(3, 9, 1));

        for (int i = 0; i < 12; i++) begin
            d = int'($urandom_range(1, 3));
            set_div(d);
            a = int'($urandom_range(0, 255));
            b = (i % 4 == 0) ? 0 : int'($urandom_range(0, 255));
            s = int'($urandom_range(0, 15));
            issue(a, b, s, 1'b0, 0, 1, ref_packet(a, b, s));
        end

        // Reset in the middle of a transfer.
        set_div(2);
        issue(1, 2, 9, 1'b0, 0, 1, ref_packet(1, 2, 9));
        repeat (10) tick();
        RESET = 1'b1;
        tick();
        check("abort_outputs", 32'({CALC_ACTIVE, CALC_MODE, BUSY, D_OUT_VALID, D_OUT, CLK_Tx}), 32'd0);
        RESET = 1'b0;
        tick(); tick();
        check("abort_stays_quiet", 32'({BUSY, D_OUT_VALID, D_OUT, CLK_Tx}), 32'd0);

        // Mode-1 activation with mismatch recovery.
        send_keys(16'b1101010, 7);
        check("mode1_active", 32'(CALC_ACTIVE), 32'd1);
        check("mode1_mode", 32'(CALC_MODE), 32'd1);

        set_div(2);
        issue(10, 7, 0, 1'b1, 0, 0, '0);
        ref_mem[0] = ref_packet(10, 7, 0);
        written.push_back(0);
        issue(28, 4, 3, 1'b1, 5, 0, '0);
        ref_mem[5] = ref_packet(28, 4, 3);
        written.push_back(5);
        issue(0, 0, 0, 1'b0, 0, 1, MEM_EN ? 32'h0A070110 : 32'h0);
        issue(0, 0, 0, 1'b0, 5, 1, MEM_EN ? 32'h1C043070 : 32'h0);

        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                a  = int'($urandom_range(0, 255));
                b  = int'($urandom_range(0, 255));
                s  = int'($urandom_range(0, 15));
                ad = int'($urandom_range(0, 255));
                issue(a, b, s, 1'b1, ad, 0, '0);
                ref_mem[ad] = ref_packet(a, b, s);
                written.push_back(ad);
            end else begin
                ad = written[$urandom_range(0, written.size() - 1)];
                issue(int'($urandom_range(0, 255)), 0, 0, 1'b0, ad, 1,
                      MEM_EN ? ref_mem[ad] : 32'h0);
            end
        end

        wait_idle();
        repeat (3) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("idle_outputs_quiet", 32'(idle_bad), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
